// File: rtl/uart_tx_arbiter_if.sv
// Requester and serializer signals of the shared UART transmit arbiter.
// master = arbiter side, slave = requesters plus serializer.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_byte;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_dv;
  logic [7:0]           tx_byte;
  logic                 tx_active;
  logic                 tx_done;
  logic                 busy;
  logic                 timeout;

  modport master (
    input  req_valid, req_byte, req_last, tx_active, tx_done,
    output req_ready, grant, tx_dv, tx_byte, busy, timeout
  );

  modport slave (
    output req_valid, req_byte, req_last, tx_active, tx_done,
    input  req_ready, grant, tx_dv, tx_byte, busy, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one uart_tx serializer between NUM_REQ
// byte-stream requesters, with inter-packet gap and stall revocation.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CLKS     = 160,
  parameter int TIMEOUT_CLKS = 65535
)(
  input logic              i_Clock,
  input logic              i_Reset_n,
  uart_tx_arbiter_if.master bus
);
  localparam int          PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] GAP_LAST = (GAP_CLKS == 0) ? 32'd0 : 32'(GAP_CLKS - 1);
  localparam logic [31:0] TO_MAX   = 32'(TIMEOUT_CLKS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_DONE, S_SETTLE, S_GAP} state_t;

  state_t               state, state_nx;
  logic [PW-1:0]        ptr, ptr_nx, gidx, gidx_nx;
  logic [NUM_REQ-1:0]   grant_q, grant_nx;
  logic                 last_q, last_nx;
  logic [7:0]           byte_q, byte_nx;
  logic [31:0]          stall_cnt, stall_nx, gap_cnt, gap_nx;
  logic                 tx_dv, timeout;
  logic                 found;
  logic [PW-1:0]        winner, idx_p;
  logic                 quiet, cur_valid;
  logic [7:0]           cur_byte;

  assign quiet     = !bus.tx_active && !bus.tx_done;
  assign cur_valid = bus.req_valid[gidx];
  assign cur_byte  = bus.req_byte[{gidx, 3'b000} +: 8];

  // First requester with Valid searching from ptr+1 upward, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx_p  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_p = PW'((int'(ptr) + i) % NUM_REQ);
      if (!found && bus.req_valid[idx_p]) begin
        found  = 1'b1;
        winner = idx_p;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    gidx_nx  = gidx;
    grant_nx = grant_q;
    last_nx  = last_q;
    byte_nx  = byte_q;
    stall_nx = stall_cnt;
    gap_nx   = gap_cnt;
    tx_dv    = 1'b0;
    timeout  = 1'b0;
    case (state)
      S_IDLE: begin
        if (found && quiet) begin
          grant_nx         = '0;
          grant_nx[winner] = 1'b1;
          gidx_nx          = winner;
          ptr_nx           = winner;
          stall_nx         = '0;
          state_nx         = S_LOAD;
        end
      end
      S_LOAD: begin
        // A strobe in a reset cycle would reach the serializer but be lost here.
        if (cur_valid && quiet && i_Reset_n) begin
          tx_dv    = 1'b1;
          byte_nx  = cur_byte;
          last_nx  = bus.req_last[gidx];
          stall_nx = '0;
          state_nx = S_WAIT_DONE;
        end else if (stall_cnt == TO_MAX) begin
          timeout  = 1'b1;
          grant_nx = '0;
          gap_nx   = '0;
          state_nx = S_GAP;
        end else begin
          stall_nx = stall_cnt + 32'd1;
        end
      end
      S_WAIT_DONE: begin
        if (bus.tx_done) state_nx = S_SETTLE;
      end
      S_SETTLE: begin
        if (quiet) begin
          if (last_q) begin
            grant_nx = '0;
            gap_nx   = '0;
            state_nx = S_GAP;
          end else begin
            stall_nx = '0;
            state_nx = S_LOAD;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = S_IDLE;
        else gap_nx = gap_cnt + 32'd1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state     <= S_IDLE;
      ptr       <= PW'(NUM_REQ - 1);
      gidx      <= '0;
      grant_q   <= '0;
      last_q    <= 1'b0;
      byte_q    <= '0;
      stall_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      gidx      <= gidx_nx;
      grant_q   <= grant_nx;
      last_q    <= last_nx;
      byte_q    <= byte_nx;
      stall_cnt <= stall_nx;
      gap_cnt   <= gap_nx;
    end
  end

  assign bus.tx_dv     = tx_dv;
  assign bus.tx_byte   = tx_dv ? cur_byte : byte_q;
  assign bus.req_ready = tx_dv ? grant_q : '0;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.timeout   = timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, serializer model and
// a byte/grant scoreboard; a second instance runs with no inter-packet gap.
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int GAP  = 5;
  localparam int TO   = 20;
  localparam int BITC = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  uart_tx_arbiter_if #(.NUM_REQ(N)) busz ();

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TO)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .bus(bus));
  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CLKS(0), .TIMEOUT_CLKS(TO)) dutz (
    .i_Clock(clk), .i_Reset_n(rst_n), .bus(busz));

  int n_chk  = 0;
  int n_fail = 0;
  int dv_cnt = 0;

  logic [8:0]   rq [N][$];
  logic [N+7:0] expq [$];
  logic [N+7:0] ex;

  logic [N-1:0]   pend = '0, r_valid = '0, r_last = '0;
  logic [8*N-1:0] r_byte = '0;
  logic s_act = 1'b0, s_done = 1'b0;
  int   s_cnt = 0, s_dcnt = 0;
  logic z_act = 1'b0, z_done = 1'b0;
  int   z_cnt = 0, z_dcnt = 0;
  logic [N-1:0] zr_valid = '0;

  assign bus.req_valid  = r_valid;
  assign bus.req_byte   = r_byte;
  assign bus.req_last   = r_last;
  assign bus.tx_active  = s_act;
  assign bus.tx_done    = s_done;
  assign busz.req_valid = zr_valid;
  assign busz.req_byte  = 32'h0000_B2A1;
  assign busz.req_last  = '1;
  assign busz.tx_active = z_act;
  assign busz.tx_done   = z_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int k, input logic [7:0] b, input logic last);
    logic [N-1:0] oh;
    oh    = '0;
    oh[k] = 1'b1;
    rq[k].push_back({last, b});
    expq.push_back({oh, b});
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int c;
    c = 0;
    while ((bus.busy || expq.size() != 0 || s_act || s_done) && c < lim) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(bus.busy || expq.size() != 0), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Requesters: a byte is popped on the negedge after its Ready was seen.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (pend[k] && rq[k].size() > 0) void'(rq[k].pop_front());
      pend[k] <= bus.req_ready[k];
      if (rq[k].size() > 0) begin
        r_valid[k]       <= 1'b1;
        r_byte[8*k +: 8] <= rq[k][0][7:0];
        r_last[k]        <= rq[k][0][8];
      end else begin
        r_valid[k]       <= 1'b0;
        r_byte[8*k +: 8] <= 8'h00;
        r_last[k]        <= 1'b0;
      end
    end
  end

  // Serializer models: BITC clocks Active, then Done held for two clocks.
  always @(posedge clk) begin
    if (bus.tx_dv) begin
      s_act <= 1'b1;
      s_cnt <= BITC;
    end else if (s_act) begin
      if (s_cnt == 1) begin
        s_act  <= 1'b0;
        s_done <= 1'b1;
        s_dcnt <= 2;
      end else s_cnt <= s_cnt - 1;
    end
    if (s_done) begin
      if (s_dcnt == 1) s_done <= 1'b0;
      else s_dcnt <= s_dcnt - 1;
    end
  end

  always @(posedge clk) begin
    if (busz.tx_dv) begin
      z_act <= 1'b1;
      z_cnt <= BITC;
    end else if (z_act) begin
      if (z_cnt == 1) begin
        z_act  <= 1'b0;
        z_done <= 1'b1;
        z_dcnt <= 2;
      end else z_cnt <= z_cnt - 1;
    end
    if (z_done) begin
      if (z_dcnt == 1) z_done <= 1'b0;
      else z_dcnt <= z_dcnt - 1;
    end
  end

  // Scoreboard: every strobe must match the next expected {grant, byte}.
  always @(negedge clk) begin
    if (bus.tx_dv) begin
      dv_cnt <= dv_cnt + 1;
      chk("dv_while_busy", 32'({s_act, s_done}), 32'd0);
      chk("dv_expected", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        ex = expq.pop_front();
        chk("dv_byte", 32'(bus.tx_byte), 32'(ex[7:0]));
        chk("dv_grant", 32'(bus.grant), 32'(ex[N+7:8]));
        chk("dv_ready", 32'(bus.req_ready), 32'(ex[N+7:8]));
      end
    end else if (bus.req_ready != '0) begin
      chk("ready_without_dv", 32'(bus.req_ready), 32'd0);
    end
    if (busz.tx_dv) chk("z_dv_while_busy", 32'({z_act, z_done}), 32'd0);
  end

  initial begin
    int c, base;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_dv", 32'(bus.tx_dv), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    chk("rst_byte", 32'(bus.tx_byte), 32'd0);
    rst_n = 1'b1;

    // Single 3-byte packet, then the idle gap.
    send(0, 8'h11, 1'b0); send(0, 8'h22, 1'b0); send(0, 8'h33, 1'b1);
    c = 0;
    while (bus.grant == '0 && c < 100) begin @(negedge clk); c++; end
    chk("t1_grant", 32'(bus.grant), 32'b0001);
    c = 0;
    while (bus.grant != '0 && c < 500) begin @(negedge clk); c++; end
    chk("t1_drained", 32'(expq.size()), 32'd0);
    c = 0;
    while (bus.busy && c < 500) begin @(negedge clk); c++; end
    chk("t1_gap_clks", 32'(c), 32'(GAP));

    // Concurrent req0/req2 with follow-up packets: 0, 2, 0, 2.
    do_reset();
    send(0, 8'hA1, 1'b0); send(0, 8'hA2, 1'b1);
    send(2, 8'hB1, 1'b0); send(2, 8'hB2, 1'b1);
    send(0, 8'hC1, 1'b1);
    send(2, 8'hD1, 1'b1);
    wait_idle("t2_drain", 3000);

    // Stall after the first byte of req1 revokes the grant.
    send(1, 8'h5A, 1'b0);
    base = dv_cnt;
    c = 0;
    while (dv_cnt == base && c < 200) begin @(negedge clk); c++; end
    c = 0;
    while (!s_done && c < 200) begin @(negedge clk); c++; end
    c = 0;
    while (s_done && c < 200) begin @(negedge clk); c++; end
    c = 0;
    while (!bus.timeout && c < 200) begin @(negedge clk); c++; end
    chk("t3_stall_clks", 32'(c), 32'(TO + 1));
    chk("t3_grant_at_timeout", 32'(bus.grant), 32'b0010);
    @(negedge clk);
    chk("t3_timeout_pulse", 32'(bus.timeout), 32'd0);
    chk("t3_grant_revoked", 32'(bus.grant), 32'd0);
    c = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.req_ready[1]) c++;
      @(negedge clk);
    end
    chk("t3_no_ready", 32'(c), 32'd0);
    wait_idle("t3_drain", 500);

    // Reset while the serializer is mid-byte of a 4-byte packet.
    send(3, 8'hE1, 1'b0); send(3, 8'hE2, 1'b0); send(3, 8'hE3, 1'b0); send(3, 8'hE4, 1'b1);
    base = dv_cnt;
    c = 0;
    while (dv_cnt < base + 2 && c < 500) begin @(negedge clk); c++; end
    chk("t4_two_bytes", 32'(dv_cnt - base), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    rq[3].delete();
    expq.delete();
    @(negedge clk);
    chk("t4_grant", 32'(bus.grant), 32'd0);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_dv", 32'(bus.tx_dv), 32'd0);
    chk("t4_ready", 32'(bus.req_ready), 32'd0);
    chk("t4_byte", 32'(bus.tx_byte), 32'd0);
    rst_n = 1'b1;
    send(1, 8'hC4, 1'b1);
    wait_idle("t4_drain", 500);

    // Four requesters, three 1-byte packets each: grants 0,1,2,3 x3.
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < N; k++)
        send(k, 8'(16 * k + p), 1'b1);
    wait_idle("t5_drain", 3000);

    // No-gap instance: back-to-back packets, grant idle for exactly 2 clocks.
    zr_valid = 4'b0011;
    c = 0;
    while (busz.grant == '0 && c < 100) begin @(negedge clk); c++; end
    for (int i = 0; i < 4; i++) begin
      chk("t6_grant_order", 32'(busz.grant), (i % 2 == 0) ? 32'b0001 : 32'b0010);
      c = 0;
      while (busz.grant != '0 && c < 200) begin @(negedge clk); c++; end
      c = 0;
      while (busz.grant == '0 && c < 200) begin @(negedge clk); c++; end
      chk("t6_gap_clks", 32'(c), 32'd2);
    end
    zr_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
